// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Serial UART transmitter. Accepts one data word per
//                valid/ready handshake and sends a frame made of a start
//                bit, DATA_BITS data bits LSB-first, an optional parity bit
//                and one or two stop bits. Each bit lasts CLKS_PER_BIT
//                clocks. Back-to-back frames run with no idle gap.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous reset, active low
//                tx_data  - word to send, sampled on the handshake edge
//                tx_valid - tx_data is valid
//                tx_ready - a word can be accepted this cycle
//                tx       - serial line, idle high (registered)
//                busy     - a frame is in progress
//                tx_done  - one-cycle pulse in the last stop-bit cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 20,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS) + 1;

  localparam logic [CW-1:0] C_BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_BAUD_PRELAST = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] C_IDX_LAST     = IW'(DATA_BITS - 1);
  localparam logic          C_STOP_LAST    = (STOP_BITS == 2);
  localparam logic          C_ODD          = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_baud_end;
  logic [DATA_BITS-1:0] w_shifted;

  assign w_accept   = tx_valid & r_ready;
  assign w_baud_end = (r_baud == C_BAUD_LAST);
  assign w_shifted  = r_shreg >> 1;

  assign tx       = r_tx;
  assign busy     = r_busy;
  assign tx_done  = r_done;
  assign tx_ready = r_ready;

  // tx_ready and tx_done are registered, so they are raised one edge early:
  // on the edge that moves the baud counter into the last cycle of the
  // last stop bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shreg    <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_accept) begin
            r_shreg    <= tx_data;
            r_parity   <= (^tx_data) ^ C_ODD;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_START;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_START: begin
          if (w_baud_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shreg[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end

        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit_idx == C_IDX_LAST) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
                r_state    <= S_STOP;
              end
            end else begin
              r_shreg   <= w_shifted;
              r_tx      <= w_shifted[0];
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end

        S_PARITY: begin
          if (w_baud_end) begin
            r_baud     <= '0;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end && (r_stop_idx == C_STOP_LAST)) begin
            // Final cycle of the frame: either chain the next word or idle.
            r_baud <= '0;
            if (w_accept) begin
              r_shreg    <= tx_data;
              r_parity   <= (^tx_data) ^ C_ODD;
              r_bit_idx  <= '0;
              r_stop_idx <= 1'b0;
              r_tx       <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end
          end else if (w_baud_end) begin
            r_baud     <= '0;
            r_stop_idx <= 1'b1;
          end else begin
            r_baud <= r_baud + CW'(1);
            if ((r_stop_idx == C_STOP_LAST) && (r_baud == C_BAUD_PRELAST)) begin
              r_ready <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter. It is the transmit-side counterpart of the existing uart receiver.
- Takes parallel bytes through a valid/ready handshake and shifts them out on a single line: start bit, data bits LSB-first, optional parity bit, one or two stop bits.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Its output feeds the receiver's rx input in loopback benches and the board TX pin in top-level builds.

Parameters:
CLKS_PER_BIT, 20, clock cycles per serial bit (must be >= 2)
DATA_BITS, 8, data bits per frame (5..8)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
tx_data  input  DATA_BITS  byte to send, sampled on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmitter can accept a byte this cycle
tx  output  1  serial line, idle high
busy  output  1  frame in progress (any state except IDLE)
tx_done  output  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, counters=0, shift register=0. Reset takes effect mid-frame too: tx returns high on the next edge and the frame is abandoned. No tx_done is issued for it.
- Handshake: a byte is accepted on an edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register, and parity is computed from the latched value.
  - tx_data may change freely after acceptance.
- tx_ready=1 in IDLE, and also in the final clock of the final stop bit. This allows gapless back-to-back frames. It is 0 at all other times.
- Latency: tx goes low (start bit) on the edge that accepts the byte, so the start bit is visible the cycle after the handshake.
- States:
  - IDLE: tx=1. On accept -> START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx=shreg[0]. Each bit is held CLKS_PER_BIT cycles, then shreg shifts right and bit_idx increments. After bit_idx=DATA_BITS-1 completes -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the data bits, XOR PARITY_ODD, held CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. In the final cycle, tx_done=1. On the next edge:
    - if an accept occurs -> START, with the new byte latched;
    - otherwise -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1. It resets to 0 on every bit boundary and on accept. Width is clog2(CLKS_PER_BIT).
- Bit index: width clog2(DATA_BITS)+1, with no wrap inside a frame.
- Frame length is exactly (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, with no extra idle cycle between back-to-back frames.
- tx_valid is ignored while tx_ready=0. No queuing and no data loss: the sender holds tx_valid until it sees tx_ready.
- busy=1 from the cycle after accept through the final stop cycle. It stays 1 across back-to-back frames.
- The tx output is registered, with no combinational path from inputs to tx.

Test Plan:
- Reset check: hold rst=0 for 5 clocks with tx_valid=1 -> tx=1, busy=0, tx_done=0, tx_ready=1 throughout; no frame starts.
- Single byte, defaults: send 0x55 -> tx low for 20 clocks, then data 1,0,1,0,1,0,1,0, each 20 clocks, then high for 20 clocks. tx_done pulses exactly once, 200 cycles after accept. The receiver in loopback reports 0x55.
- Back-to-back: hold tx_valid=1 with 0xA3 then 0x0F -> second start bit begins immediately after the first stop bit (no idle cycle); busy stays 1 for 400 cycles; two tx_done pulses 200 apart.
- Parity/stop options: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, send 0x07 -> parity bit=1, followed by 40 high cycles; frame is 240 cycles. Repeat with PARITY_ODD=1 -> parity bit=0.
- Reset mid-frame: assert rst=0 during data bit 3 of 0xFF -> tx=1 on the next edge; no tx_done. After rst=1, sending 0x00 yields a clean frame: start bit, 8 low data bits, then high.
- Handshake stall: pulse tx_valid for one cycle while busy -> ignored. Frame output is unchanged and no extra frame is sent.
